// File: rtl/am_lock_n_rx.sv
// Per-lane alignment marker lock and BIP3 monitor for 40G/100G BASE-R receive PCS.
// Finds the lane marker, confirms it one period later, tracks lock with mismatch tolerance.
module am_lock_n_rx #(
    parameter  int BLOCK_W   = 66,
    parameter  int LANE_N    = 4,
    parameter  int GAP_N     = 16383,
    parameter  int NV_MAX    = 4,
    parameter  int CNT_W     = 16,
    localparam int LANE_ID_W = $clog2(LANE_N)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 signal_ok_i,
    input  logic                 block_v_i,
    input  logic [BLOCK_W-1:0]   block_i,
    input  logic                 bip_cnt_clr_i,
    output logic                 lock_o,
    output logic [LANE_ID_W-1:0] lane_o,
    output logic [LANE_N-1:0]    lane_oh_o,
    output logic                 am_v_o,
    output logic                 slip_o,
    output logic                 bip_err_o,
    output logic [CNT_W-1:0]     bip_err_cnt_o
);

    localparam int GAP_W = $clog2(GAP_N + 1);
    localparam int NV_W  = $clog2(NV_MAX + 1);

    if (!(LANE_N == 4 || LANE_N == 20)) begin : g_bad_lane_n
        $error("am_lock_n_rx: LANE_N must be 4 or 20");
    end
    if (BLOCK_W != 66) begin : g_bad_block_w
        $error("am_lock_n_rx: BLOCK_W must be 66");
    end

    typedef enum logic [3:0] {
        S_INVALID = 4'b0001,
        S_SYNC    = 4'b0010,
        S_FIRST   = 4'b0100,
        S_LOCK    = 4'b1000
    } state_t;

    // Marker bytes {M0, M1, M2}; M4..M6 are their bitwise inverse.
    function automatic logic [23:0] am_code(input int unsigned lane);
        logic [23:0] c;
        c = '0;
        if (LANE_N == 4) begin
            case (lane)
                0:       c = 24'h907647;
                1:       c = 24'hF0C4E6;
                2:       c = 24'hC5659B;
                3:       c = 24'hA2793D;
                default: c = '0;
            endcase
        end else begin
            case (lane)
                0:       c = 24'hC16821;
                1:       c = 24'h9D718E;
                2:       c = 24'h594BE8;
                3:       c = 24'h4D957B;
                4:       c = 24'hF50709;
                5:       c = 24'hDD14C2;
                6:       c = 24'h9A4A26;
                7:       c = 24'h7B4566;
                8:       c = 24'hA02476;
                9:       c = 24'h68C9FB;
                10:      c = 24'hFD6C99;
                11:      c = 24'hB99155;
                12:      c = 24'h5CB9B2;
                13:      c = 24'h1AF8BD;
                14:      c = 24'h83C7CA;
                15:      c = 24'h3536CD;
                16:      c = 24'hC4314C;
                17:      c = 24'hADD6B7;
                18:      c = 24'h5F662A;
                19:      c = 24'hC0F0E5;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    // BIP3 contribution: XOR of the eight payload bytes, sync bits folded into bits 3 and 4.
    function automatic logic [7:0] bip_of(input logic [BLOCK_W-1:0] b);
        logic [7:0] p;
        p = '0;
        for (int unsigned j = 0; j < 8; j++) p ^= b[2 + 8*j +: 8];
        p[3] ^= b[0];
        p[4] ^= b[1];
        return p;
    endfunction

    state_t                 state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [NV_W-1:0]        nv_q, nv_d;
    logic [LANE_ID_W-1:0]   lane_q, lane_d;
    logic [7:0]             acc_q, acc_d, blk_bip;
    logic [CNT_W-1:0]       cnt_q;
    logic                   am_v_q, slip_q, bip_err_q;
    logic                   am_v_d, slip_d, bip_err_d;

    logic [LANE_N-1:0]      lane_match;
    logic [LANE_ID_W-1:0]   match_idx;
    logic                   any_match, at_exp, same, nv_last;
    logic [23:0]            rx_m012, rx_m456;

    assign rx_m012 = {block_i[9:2], block_i[17:10], block_i[25:18]};
    assign rx_m456 = {block_i[41:34], block_i[49:42], block_i[57:50]};
    assign blk_bip = bip_of(block_i);

    always_comb begin
        lane_match = '0;
        match_idx  = '0;
        for (int unsigned i = 0; i < LANE_N; i++) begin
            lane_match[i] = (block_i[1:0] == 2'b10) && (rx_m012 == am_code(i))
                            && (rx_m456 == ~am_code(i));
            if (lane_match[i]) match_idx = LANE_ID_W'(i);
        end
    end

    assign any_match = |lane_match;
    assign at_exp    = block_v_i && (gap_q == GAP_W'(GAP_N));
    assign same      = lane_match[lane_q];
    assign nv_last   = (nv_q == NV_W'(NV_MAX - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= S_INVALID;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!signal_ok_i) begin
            state_d = S_INVALID;
        end else if (block_v_i) begin
            case (state_q)
                S_INVALID: state_d = S_SYNC;
                S_SYNC:    if (any_match) state_d = S_FIRST;
                S_FIRST:   if (at_exp) state_d = same ? S_LOCK : S_SYNC;
                S_LOCK:    if (at_exp && !same && nv_last) state_d = S_SYNC;
                default:   state_d = S_INVALID;
            endcase
        end
    end

    always_comb begin
        am_v_d    = 1'b0;
        slip_d    = 1'b0;
        bip_err_d = 1'b0;
        if (signal_ok_i && at_exp && (state_q == S_FIRST || state_q == S_LOCK)) begin
            if (same) begin
                am_v_d    = 1'b1;
                bip_err_d = (acc_q != block_i[33:26]);
            end else if (state_q == S_FIRST || nv_last) begin
                slip_d = 1'b1;
            end
        end
    end

    // Gap and accumulator re-seed at every expected position, matched or not.
    always_comb begin
        gap_d  = gap_q;
        nv_d   = nv_q;
        lane_d = lane_q;
        acc_d  = acc_q;
        if (!signal_ok_i) begin
            gap_d  = '0;
            nv_d   = '0;
            lane_d = '0;
            acc_d  = '0;
        end else if (block_v_i) begin
            case (state_q)
                S_SYNC: begin
                    gap_d = '0;
                    nv_d  = '0;
                    if (any_match) begin
                        lane_d = match_idx;
                        acc_d  = blk_bip;
                    end
                end
                S_FIRST, S_LOCK: begin
                    if (at_exp) begin
                        gap_d = '0;
                        acc_d = blk_bip;
                        nv_d  = (same || nv_last || state_q == S_FIRST) ? '0 : nv_q + 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                        acc_d = acc_q ^ blk_bip;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            gap_q     <= '0;
            nv_q      <= '0;
            lane_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            am_v_q    <= 1'b0;
            slip_q    <= 1'b0;
            bip_err_q <= 1'b0;
        end else begin
            gap_q     <= gap_d;
            nv_q      <= nv_d;
            lane_q    <= lane_d;
            acc_q     <= acc_d;
            am_v_q    <= am_v_d;
            slip_q    <= slip_d;
            bip_err_q <= bip_err_d;
            if (bip_cnt_clr_i)                   cnt_q <= bip_err_d ? CNT_W'(1) : '0;
            else if (bip_err_d && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        lane_oh_o = '0;
        if (state_q == S_FIRST || state_q == S_LOCK) lane_oh_o[lane_q] = 1'b1;
    end

    assign lock_o        = (state_q == S_LOCK);
    assign lane_o        = lane_q;
    assign am_v_o        = am_v_q;
    assign slip_o        = slip_q;
    assign bip_err_o     = bip_err_q;
    assign bip_err_cnt_o = cnt_q;

endmodule
